mac_result_collector: RTL and testbench

Downstream consumer of the MAC engine's valid/ready output. It captures each finished 20-bit accumulated sum and requantizes it to 8 bits with a rounding arithmetic shift and saturation. Results are buffered in a small FIFO and drained through a second valid/ready port toward the activation writeback buffer. It replaces the engine's unused internal output-buffer path and decouples engine batch completion from writeback stalls.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/mac_result_fifo.sv | 81 ++++++++
 rtl/mac_result_collector.sv | 163 ++++++++++++++++
 tb/tb_mac_result_collector.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared MAC definitions: default datapath widths, engine mode codes and
// helpers that give the signed saturation bounds for a result width.
// Imported by the MAC engine and by the result collector.
package mac_pkg;

    // Default widths of the accumulated sum and of the requantized result
    localparam int SUM_W_DEF = 20;
    localparam int OUT_W_DEF = 8;

    // Operand precision modes, shared with the engine
    localparam logic [1:0] MODE_2BX2B = 2'd0;
    localparam logic [1:0] MODE_4BX4B = 2'd1;
    localparam logic [1:0] MODE_8BX8B = 2'd2;

    // Saturation bounds of the default result width
    localparam int OUT_MAX_DEF = (1 << (OUT_W_DEF - 1)) - 1;
    localparam int OUT_MIN_DEF = -(1 << (OUT_W_DEF - 1));

    // Largest and smallest value representable in a signed w-bit result
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Result FIFO: DEPTH x W storage, wrapping pointers and a separate count.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: no internal stall; the writer must never push when full.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous flush (beats push and pop)
//   push_i, push_dat_i  write tail
//   pop_i               remove head (ignored while empty)
//   vld_o, dat_o        head valid / head data
//   cnt_o               number of stored entries
module mac_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic          vld_o,
    output logic [W-1:0]  dat_o,
    output logic [CW-1:0] cnt_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    assign do_pop = pop_i & (cnt_q != '0);

    // Pointers are exactly AW bits wide, so DEPTH being a power of two
    // makes the increment wrap modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_i);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            cnt_d    = cnt_q + CW'(push_i) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is reset so the head reads zero straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign vld_o = (cnt_q != '0);
    assign dat_o = mem_q[rd_ptr_q];
    assign cnt_o = cnt_q;

endmodule

// File: rtl/mac_result_collector.sv
// Captures MAC engine sums, requantizes them (rounding shift + saturate), queues them.
// Latency: 2 cycles from upstream transfer to out_valid (S1 register, then FIFO).
// Backpressure: mac_ready drops once S1 + FIFO hold DEPTH results; S1 never stalls.
//
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   clear                  synchronous flush of S1, FIFO, sat_flag and result_count
//   shift                  right-shift amount, latched with each captured sum
//   mac_valid/mac_ready    upstream handshake, mac_sum is the accumulated sum
//   out_valid/out_ready    downstream handshake, out_data is the FIFO head
//   sat_flag               sticky: some result was clamped
//   result_count           upstream transfers since reset/clear, wraps at 2^16
//
// Build option MAC_COLLECTOR_RELU_EN: negative results clamp to zero without
// setting sat_flag; only positive overflow is flagged.
module mac_result_collector
    import mac_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SUM_W = SUM_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic [4:0]       shift,
    input  logic             mac_valid,
    input  logic [SUM_W-1:0] mac_sum,
    output logic             mac_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             sat_flag,
    output logic [15:0]      result_count
);

    localparam int CW    = $clog2(DEPTH) + 1;
    // One extra bit so the rounding bias can never overflow the sum.
    localparam int EXT_W = SUM_W + 1;

    localparam logic signed [EXT_W-1:0] Q_MAX_X = EXT_W'(sat_max(OUT_W));
    localparam logic [OUT_W-1:0]        Q_MAX_O = Q_MAX_X[OUT_W-1:0];
`ifndef MAC_COLLECTOR_RELU_EN
    localparam logic signed [EXT_W-1:0] Q_MIN_X = EXT_W'(sat_min(OUT_W));
    localparam logic [OUT_W-1:0]        Q_MIN_O = Q_MIN_X[OUT_W-1:0];
`endif

    // S1 capture register
    logic             s1_vld_q, s1_vld_d;
    logic [SUM_W-1:0] s1_sum_q, s1_sum_d;
    logic [4:0]       s1_shift_q, s1_shift_d;

    logic             sat_q, sat_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             xfer;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_vld;
    logic [CW-1:0]    fifo_cnt;
    logic [CW:0]      occupancy;

    logic signed [EXT_W-1:0] sum_ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;
    logic [OUT_W-1:0]        q_dat;
    logic                    q_sat;

    // Ready depends only on registers, so the engine never sees a
    // combinational path from out_ready.
    assign occupancy = {1'b0, fifo_cnt} + {{CW{1'b0}}, s1_vld_q};
    assign mac_ready = (occupancy < (CW+1)'(DEPTH));
    assign xfer      = mac_valid & mac_ready;
    assign fifo_push = s1_vld_q & ~clear;
    assign fifo_pop  = fifo_vld & out_ready & ~clear;

    // Requantize S1: round half up, arithmetic shift, then clamp.
    always_comb begin
        sum_ext = $signed({s1_sum_q[SUM_W-1], s1_sum_q});
        rnd     = '0;
        if (s1_shift_q != 5'd0) begin
            rnd = EXT_W'(1) << (s1_shift_q - 5'd1);
        end
        biased  = sum_ext + rnd;
        shifted = biased >>> s1_shift_q;
        q_dat   = shifted[OUT_W-1:0];
        q_sat   = 1'b0;
`ifdef MAC_COLLECTOR_RELU_EN
        if (shifted[EXT_W-1]) begin
            q_dat = '0;
        end else if (shifted > Q_MAX_X) begin
            q_dat = Q_MAX_O;
            q_sat = 1'b1;
        end
`else
        if (shifted > Q_MAX_X) begin
            q_dat = Q_MAX_O;
            q_sat = 1'b1;
        end else if (shifted < Q_MIN_X) begin
            q_dat = Q_MIN_O;
            q_sat = 1'b1;
        end
`endif
    end

    // S1 empties into the FIFO every edge unless a new transfer reloads it.
    always_comb begin
        s1_vld_d   = 1'b0;
        s1_sum_d   = s1_sum_q;
        s1_shift_d = s1_shift_q;
        sat_d      = sat_q;
        cnt_d      = cnt_q;
        if (clear) begin
            sat_d = 1'b0;
            cnt_d = '0;
        end else begin
            if (xfer) begin
                s1_vld_d   = 1'b1;
                s1_sum_d   = mac_sum;
                s1_shift_d = shift;
                cnt_d      = cnt_q + 16'd1;
            end
            sat_d = sat_q | (s1_vld_q & q_sat);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_vld_q   <= 1'b0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_sum_q   <= s1_sum_d;
            s1_shift_q <= s1_shift_d;
            sat_q      <= sat_d;
            cnt_q      <= cnt_d;
        end
    end

    mac_result_fifo #(
        .DEPTH (DEPTH),
        .W     (OUT_W)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (nrst),
        .clear_i    (clear),
        .push_i     (fifo_push),
        .push_dat_i (q_dat),
        .pop_i      (fifo_pop),
        .vld_o      (fifo_vld),
        .dat_o      (out_data),
        .cnt_o      (fifo_cnt)
    );

    assign out_valid    = fifo_vld;
    assign sat_flag     = sat_q;
    assign result_count = cnt_q;

endmodule

// File: tb/tb_mac_result_collector.sv
// Bench for mac_result_collector: directed scenarios plus random traffic,
// all compared against a queue-based reference model of results in flight.
// Build with MAC_COLLECTOR_RELU_EN defined to exercise the ReLU variant.
module tb_mac_result_collector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  shift = '0;
    logic        mac_valid = 1'b0;
    logic [19:0] mac_sum = '0;
    logic        mac_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        sat_flag;
    logic [15:0] result_count;

    always #5 clk = ~clk;

    mac_result_collector #(
        .DEPTH (DEPTH),
        .SUM_W (20),
        .OUT_W (8)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .clear        (clear),
        .shift        (shift),
        .mac_valid    (mac_valid),
        .mac_sum      (mac_sum),
        .mac_ready    (mac_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .sat_flag     (sat_flag),
        .result_count (result_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: every accepted result in order, tagged with the edge
    // at which it was accepted. It becomes visible one edge later.
    typedef struct {
        int res;
        bit sat;
        int edge_no;
    } item_t;

    item_t mq[$];
    int    m_edges = 0;
    int    m_cnt   = 0;
    bit    m_sat   = 1'b0;

    // Requantize with plain integer arithmetic (floor division).
    function automatic void ref_q(input int sum, input int sh, output int r, output bit sat);
        longint d, v, qv;
        d = longint'(1) << sh;
        v = longint'(sum) + ((sh != 0) ? d / 2 : 0);
        if (v >= 0) qv = v / d;
        else        qv = -((-v + d - 1) / d);
        sat = 1'b0;
`ifdef MAC_COLLECTOR_RELU_EN
        if (qv < 0) qv = 0;
`endif
        if (qv > 127) begin
            qv  = 127;
            sat = 1'b1;
        end else if (qv < -128) begin
            qv  = -128;
            sat = 1'b1;
        end
        r = int'(qv);
    endfunction

    function automatic bit exp_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit exp_vld();
        return (mq.size() > 0) && (mq[0].edge_no <= m_edges - 1);
    endfunction

    // One clock: check outputs at the falling edge, then advance the model
    // across the rising edge. Returns 1 time unit after the rising edge.
    task automatic cycle();
        bit xf, pp, clr, s;
        int r, sv;
        @(negedge clk);
        check("mac_ready", 32'(mac_ready), 32'(exp_ready()));
        check("out_valid", 32'(out_valid), 32'(exp_vld()));
        if (exp_vld()) check("out_data", 32'(out_data), 32'(mq[0].res & 255));
        check("sat_flag", 32'(sat_flag), 32'(m_sat));
        check("result_count", 32'(result_count), 32'(m_cnt));
        xf  = mac_valid && exp_ready();
        pp  = exp_vld() && out_ready;
        clr = clear;
        sv  = $signed(mac_sum);
        ref_q(sv, int'(shift), r, s);
        @(posedge clk);
        m_edges++;
        if (clr) begin
            mq.delete();
            m_cnt = 0;
            m_sat = 1'b0;
        end else begin
            foreach (mq[i]) begin
                if (mq[i].edge_no == m_edges - 1 && mq[i].sat) m_sat = 1'b1;
            end
            if (pp) void'(mq.pop_front());
            if (xf) begin
                mq.push_back('{r, s, m_edges});
                m_cnt = (m_cnt + 1) % 65536;
            end
        end
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_mac_ready", 32'(mac_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        check("rst_result_count", 32'(result_count), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        m_edges++;
        #1;

        // In-range result appears two cycles after the transfer
        out_ready = 1'b1;
        shift     = 5'd4;
        mac_sum   = 20'h00123;
        mac_valid = 1'b1;
        cycle();
        mac_valid = 1'b0;
        cycle();
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'h12);
        check("t1_sat_flag", 32'(sat_flag), 32'd0);
        check("t1_result_count", 32'(result_count), 32'd1);
        cycle();
        cycle();

        // Positive overflow saturates and the flag sticks until clear
        mac_sum   = 20'h0FFFF;
        mac_valid = 1'b1;
        cycle();
        mac_valid = 1'b0;
        cycle();
        check("t2_out_data", 32'(out_data), 32'h7F);
        check("t2_sat_flag", 32'(sat_flag), 32'd1);
        mac_sum   = 20'h00020;
        mac_valid = 1'b1;
        cycle();
        mac_valid = 1'b0;
        repeat (3) cycle();
        check("t2_sat_sticky", 32'(sat_flag), 32'd1);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("t2_sat_cleared", 32'(sat_flag), 32'd0);
        cycle();

        // Negative value: rounded shift, or zero in the ReLU build
        shift     = 5'd2;
        mac_sum   = 20'hFFF00;
        mac_valid = 1'b1;
        cycle();
        mac_valid = 1'b0;
        cycle();
`ifdef MAC_COLLECTOR_RELU_EN
        check("t3_out_data", 32'(out_data), 32'h00);
`else
        check("t3_out_data", 32'(out_data), 32'hC0);
`endif
        check("t3_sat_flag", 32'(sat_flag), 32'd0);
        repeat (2) cycle();

        // Fill to DEPTH with the output stalled, then drain in order
        out_ready = 1'b0;
        shift     = 5'd0;
        mac_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mac_sum = 20'(i);
            cycle();
        end
        mac_valid = 1'b0;
        check("t4_ready_low", 32'(mac_ready), 32'd0);
        repeat (2) cycle();
        check("t4_head_first", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        cycle();
        check("t4_ready_back", 32'(mac_ready), 32'd1);
        check("t4_head_second", 32'(out_data), 32'h02);
        repeat (5) cycle();

        // Streaming: one entry in the FIFO, push and pop every edge,
        // pointers wrap many times
        mac_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            mac_sum = 20'(i + 16);
            cycle();
        end
        mac_valid = 1'b0;
        repeat (3) cycle();

        // Asynchronous reset with three FIFO entries and S1 occupied
        out_ready = 1'b0;
        mac_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mac_sum = 20'(i * 3);
            cycle();
        end
        mac_valid = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        check("t6_async_out_valid", 32'(out_valid), 32'd0);
        check("t6_async_count", 32'(result_count), 32'd0);
        mq.delete();
        m_cnt = 0;
        m_sat = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("t6_ready_after_rst", 32'(mac_ready), 32'd1);
        @(posedge clk);
        m_edges++;
        #1;

        // Clear coinciding with a transfer enqueues nothing
        out_ready = 1'b1;
        clear     = 1'b1;
        mac_sum   = 20'h00050;
        mac_valid = 1'b1;
        cycle();
        clear     = 1'b0;
        mac_valid = 1'b0;
        repeat (2) cycle();
        check("t7_out_valid", 32'(out_valid), 32'd0);
        check("t7_count", 32'(result_count), 32'd0);

        // Random traffic
        repeat (3000) begin
            mac_valid = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 7);
            shift     = 5'($urandom_range(0, 19));
            if ($urandom_range(0, 1) == 1) mac_sum = 20'($urandom);
            else                           mac_sum = 20'($urandom_range(0, 4095)) - 20'd2048;
            clear = ($urandom_range(0, 99) == 0);
            cycle();
        end
        mac_valid = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (8) cycle();
        check("final_drained", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
